// File: rtl/pipe_run_sequencer.sv
// Host-side preload and run sequencer for the 4-stage pipeline CPU.
// Turns host write commands into memory/regfile strobes, then runs the loaded program and drains the pipeline.
module pipe_run_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_target,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              start,
  output logic              imem_we,
  output logic              rf_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pc_clr,
  output logic              cpu_en,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   prog_len,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DRAIN_LEN = (ADDR_W+1)'(PIPE_DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              hs, start_ok;
  logic              pc_clr_n, cpu_en_n, fetch_en_n, busy_n, done_n, cmd_ready_n;
  logic [ADDR_W:0]   addr_p1;

  assign hs       = cmd_valid && cmd_ready;
  assign start_ok = start && !cmd_valid && cmd_ready;
  assign addr_p1  = {1'b0, cmd_addr} + (ADDR_W+1)'(1);

  // cnt is the RUN slot index (0 = pc clear, 1..prog_len = fetch) and the DRAIN slot index; it is one bit wider than an address so a full-depth program does not wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE, DONE: begin
        if (hs) begin
          state_n = IDLE;
        end else if (start_ok) begin
          if (prog_len == '0) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            cnt_n   = '0;
          end
        end
      end
      RUN: begin
        if (cnt == prog_len) begin
          if (DRAIN_LEN == '0) begin
            state_n = DONE;
          end else begin
            state_n = DRAIN;
            cnt_n   = (ADDR_W+1)'(1);
          end
        end else begin
          cnt_n = cnt + (ADDR_W+1)'(1);
        end
      end
      DRAIN: begin
        if (cnt >= DRAIN_LEN) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt + (ADDR_W+1)'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    pc_clr_n    = (state_n == RUN) && (cnt_n == '0);
    fetch_en_n  = (state_n == RUN) && (cnt_n != '0);
    cpu_en_n    = fetch_en_n || (state_n == DRAIN);
    busy_n      = (state_n == RUN) || (state_n == DRAIN);
    done_n      = (state_n == DONE);
    cmd_ready_n = (state_n == IDLE) || (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_ready  <= 1'b1;
      imem_we    <= 1'b0;
      rf_we      <= 1'b0;
      dmem_we    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pc_clr     <= 1'b0;
      cpu_en     <= 1'b0;
      fetch_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      prog_len   <= '0;
      run_cycles <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_ready <= cmd_ready_n;
      pc_clr    <= pc_clr_n;
      cpu_en    <= cpu_en_n;
      fetch_en  <= fetch_en_n;
      busy      <= busy_n;
      done      <= done_n;
      imem_we   <= 1'b0;
      rf_we     <= 1'b0;
      dmem_we   <= 1'b0;

      if (hs) begin
        wr_addr <= cmd_addr;
        wr_data <= cmd_data;
        case (cmd_target)
          2'b00: begin
            imem_we <= 1'b1;
            if (addr_p1 > prog_len) prog_len <= addr_p1;
          end
          2'b01: begin
            if (cmd_addr[ADDR_W-1:2] == '0) rf_we <= 1'b1;
            else                            err   <= 1'b1;
          end
          2'b10:   dmem_we <= 1'b1;
          default: err     <= 1'b1;
        endcase
      end

      // cpu_en is the registered enable, so each counted cycle lands one clock after the enable was seen.
      if (start_ok) begin
        run_cycles <= '0;
      end else if (cpu_en && (run_cycles != {CNT_W{1'b1}})) begin
        run_cycles <= run_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_run_sequencer.sv
// Directed bench for pipe_run_sequencer: write strobes are scored through a queue, run timing against a cycle model.
module tb_pipe_run_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_target;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       start;
  logic       imem_we, rf_we, dmem_we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       pc_clr, cpu_en, fetch_en, busy, done, err;
  logic [4:0] prog_len;
  logic [7:0] run_cycles;

  typedef struct {
    logic [1:0] tgt;
    logic [3:0] addr;
    logic [7:0] data;
    int         due;
  } wr_item_t;

  wr_item_t exp_q[$];
  wr_item_t mon_item;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int t0;

  pipe_run_sequencer #(.ADDR_W(4), .DATA_W(8), .PIPE_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .start(start),
    .imem_we(imem_we), .rf_we(rf_we), .dmem_we(dmem_we),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_clr(pc_clr), .cpu_en(cpu_en), .fetch_en(fetch_en),
    .busy(busy), .done(done), .err(err),
    .prog_len(prog_len), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] strobe_of(input logic [1:0] tgt);
    case (tgt)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Every strobe must match the oldest queued write, on the cycle it is due.
  always @(negedge clk) begin
    if (imem_we || rf_we || dmem_we) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_strobe", {29'd0, imem_we, rf_we, dmem_we}, 32'd0);
      end else begin
        mon_item = exp_q.pop_front();
        check_output("strobe_sel", {29'd0, imem_we, rf_we, dmem_we}, {29'd0, strobe_of(mon_item.tgt)});
        check_output("wr_addr", {28'd0, wr_addr}, {28'd0, mon_item.addr});
        check_output("wr_data", {24'd0, wr_data}, {24'd0, mon_item.data});
        check_output("strobe_cycle", cyc, mon_item.due);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      mon_item = exp_q.pop_front();
      check_output("missing_strobe", {29'd0, imem_we, rf_we, dmem_we}, {29'd0, strobe_of(mon_item.tgt)});
    end
  end

  task automatic apply_cmd(input logic [1:0] tgt, input logic [3:0] addr, input logic [7:0] data);
    int waited = 0;
    wr_item_t it;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_addr   = addr;
    cmd_data   = data;
    while (!cmd_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("cmd_ready", cmd_ready, 1);
    if (cmd_ready && (tgt == 2'b00 || tgt == 2'b10 || (tgt == 2'b01 && addr[3:2] == 2'b00))) begin
      it.tgt = tgt; it.addr = addr; it.data = data; it.due = cyc + 1;
      exp_q.push_back(it);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic apply_start(output int t_start);
    @(posedge clk); #1;
    start     = 1'b1;
    cmd_valid = 1'b0;
    t_start   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k counts cycles after the start cycle: slot 1 clears the PC, slots 2..len+1 fetch, then three drain slots, then done.
  task automatic check_run(input int len);
    for (int k = 1; k <= len + 5; k++) begin
      @(negedge clk);
      check_output($sformatf("pc_clr_k%0d", k), pc_clr, (len > 0 && k == 1));
      check_output($sformatf("fetch_en_k%0d", k), fetch_en, (len > 0 && k >= 2 && k <= len + 1));
      check_output($sformatf("cpu_en_k%0d", k), cpu_en, (len > 0 && k >= 2 && k <= len + 4));
      check_output($sformatf("busy_k%0d", k), busy, (len > 0 && k <= len + 4));
      check_output($sformatf("done_k%0d", k), done, (len == 0) ? 1'b1 : (k >= len + 5));
    end
  endtask

  initial begin
    wr_item_t it;
    rst = 1'b1; cmd_valid = 1'b0; cmd_target = 2'b00; cmd_addr = 4'd0; cmd_data = 8'd0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_cpu_en", cpu_en, 0);
    check_output("rst_err", err, 0);
    check_output("rst_prog_len", prog_len, 0);
    check_output("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;

    $display("[TB] zero-length start");
    apply_start(t0);
    check_run(0);
    check_output("zero_run_cycles", run_cycles, 0);

    $display("[TB] preload program, registers and data");
    apply_cmd(2'b00, 4'd0, 8'h06);
    check_output("done_dropped_by_cmd", done, 0);
    apply_cmd(2'b00, 4'd1, 8'h5B);
    apply_cmd(2'b00, 4'd2, 8'hA3);
    apply_cmd(2'b01, 4'd1, 8'd5);
    apply_cmd(2'b01, 4'd2, 8'd3);
    apply_cmd(2'b01, 4'd3, 8'd2);
    apply_cmd(2'b10, 4'd3, 8'd99);
    check_output("prog_len_after_preload", prog_len, 3);
    apply_cmd(2'b00, 4'd0, 8'h06);
    check_output("prog_len_no_decrease", prog_len, 3);

    $display("[TB] run three-instruction program");
    apply_start(t0);
    check_run(3);
    check_output("run_cycles_L3", run_cycles, 6);
    @(negedge clk);
    check_output("done_held", done, 1);
    check_output("run_cycles_held", run_cycles, 6);

    $display("[TB] illegal commands");
    apply_cmd(2'b11, 4'd2, 8'hAA);
    check_output("err_after_target11", err, 1);
    apply_cmd(2'b01, 4'd5, 8'h55);
    check_output("err_sticky", err, 1);
    check_output("prog_len_after_illegal", prog_len, 3);

    $display("[TB] start while command valid");
    @(posedge clk); #1;
    start = 1'b1; cmd_valid = 1'b1; cmd_target = 2'b10; cmd_addr = 4'd4; cmd_data = 8'h11;
    check_output("contend_ready", cmd_ready, 1);
    it.tgt = 2'b10; it.addr = 4'd4; it.data = 8'h11; it.due = cyc + 1;
    exp_q.push_back(it);
    @(posedge clk); #1;
    start = 1'b0; cmd_valid = 1'b0;
    check_output("contend_no_busy", busy, 0);
    check_output("contend_no_pc_clr", pc_clr, 0);
    @(posedge clk); #1;
    check_output("contend_still_idle", busy, 0);

    $display("[TB] command held during run");
    apply_start(t0);
    cmd_valid = 1'b1; cmd_target = 2'b10; cmd_addr = 4'd7; cmd_data = 8'h3C;
    for (int k = 1; k <= 8; k++) begin
      check_output($sformatf("run_cmd_ready_k%0d", k), cmd_ready, (k == 8));
      check_output($sformatf("run_busy_k%0d", k), busy, (k <= 7));
      if (k == 8) begin
        check_output("run_done_before_cmd", done, 1);
        it.tgt = 2'b10; it.addr = 4'd7; it.data = 8'h3C; it.due = cyc + 1;
        exp_q.push_back(it);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check_output("done_cleared_by_cmd", done, 0);
    check_output("idle_after_cmd_busy", busy, 0);
    check_output("idle_after_cmd_ready", cmd_ready, 1);
    check_output("run_cycles_second_run", run_cycles, 6);

    $display("[TB] reset during drain");
    apply_start(t0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_output("drain_cpu_en", cpu_en, 1);
    check_output("drain_fetch_en", fetch_en, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_cpu_en", cpu_en, 0);
    check_output("midrst_err", err, 0);
    check_output("midrst_prog_len", prog_len, 0);
    check_output("midrst_run_cycles", run_cycles, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("midrst_done", done, 0);

    $display("[TB] zero-length start after reset");
    apply_start(t0);
    check_run(0);
    check_output("zero_run_cycles_2", run_cycles, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
